// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak output stage: mode encoding, FSM states and
// per-mode rate/digest-length lookups.
package keccak_pkg;

    localparam int unsigned StateW = 1600;
    localparam int unsigned IdxW   = 8;

    typedef enum logic [2:0] {
        CmSha3_224 = 3'd0,
        CmSha3_256 = 3'd1,
        CmSha3_384 = 3'd2,
        CmSha3_512 = 3'd3,
        CmShake128 = 3'd4,
        CmShake256 = 3'd5
    } cmode_e;

    typedef enum logic [1:0] {StIdle, StWait, StStream, StReq} sq_state_e;

    function automatic int unsigned rate_bits(input logic [2:0] cm);
        int unsigned r;
        case (cmode_e'(cm))
            CmSha3_224: r = 1152;
            CmSha3_256: r = 1088;
            CmSha3_384: r = 832;
            CmSha3_512: r = 576;
            CmShake128: r = 1344;
            CmShake256: r = 1088;
            default:    r = 0;
        endcase
        return r;
    endfunction

    function automatic int unsigned sha3_len(input logic [2:0] cm);
        int unsigned l;
        case (cmode_e'(cm))
            CmSha3_224: l = 224;
            CmSha3_256: l = 256;
            CmSha3_384: l = 384;
            CmSha3_512: l = 512;
            default:    l = 0;
        endcase
        return l;
    endfunction

    function automatic logic is_shake(input logic [2:0] cm);
        return (cm == CmShake128) || (cm == CmShake256);
    endfunction

    function automatic logic cmode_legal(input logic [2:0] cm);
        return cm <= CmShake256;
    endfunction

    // Every legal beat width divides every rate exactly.
    function automatic bit out_w_legal(input int unsigned w);
        return (w == 8) || (w == 16) || (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/squeeze_word_sel.sv
// Selects beat idx of the held state and zeroes bits beyond the remaining
// length on the final beat.
module squeeze_word_sel
    import keccak_pkg::*;
#(
    parameter int unsigned OUT_W = 32,
    parameter int unsigned D_W   = 16
) (
    input  logic [StateW-1:0] state,
    input  logic [IdxW-1:0]   idx,
    input  logic [D_W-1:0]    remaining,
    input  logic              last,
    output logic [OUT_W-1:0]  word
);

    logic [10:0]      base;
    logic [OUT_W-1:0] raw;

    always_comb begin
        base = 11'(idx) * 11'(OUT_W);
        raw  = state[base +: OUT_W];
        for (int unsigned i = 0; i < OUT_W; i++) begin
            word[i] = raw[i] & (~last | (D_W'(i) < remaining));
        end
    end

endmodule

// File: rtl/keccak_squeeze_out.sv
// Streaming squeeze stage: holds the permuted state, emits the digest in OUT_W
// beats under valid/ready and requests extra permutations for long SHAKE output.
module keccak_squeeze_out
    import keccak_pkg::*;
#(
    parameter int unsigned OUT_W = 32,
    parameter int unsigned D_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        cmode,
    input  logic [D_W-1:0]    d,
    input  logic [StateW-1:0] state_i,
    input  logic              state_vld,
    output logic [OUT_W-1:0]  dt_o,
    output logic              dt_vld,
    input  logic              dt_rdy,
    output logic              dt_last,
    output logic              perm_req,
    output logic              busy,
    output logic              err
);

    if (!out_w_legal(OUT_W)) begin : g_out_w_check
        $error("OUT_W must be 8, 16, 32 or 64");
    end

    sq_state_e         st_q, st_d;
    logic [2:0]        mode_q, mode_d;
    logic [D_W-1:0]    rem_q, rem_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [StateW-1:0] held_q, held_d;
    logic              err_q, err_d;

    logic              start_ok, stream, xfer, last;
    logic [D_W-1:0]    start_len, take;
    logic [IdxW-1:0]   rw;
    logic [OUT_W-1:0]  word;

    assign start_ok  = cmode_legal(cmode) && !(is_shake(cmode) && (d == '0));
    assign start_len = is_shake(cmode) ? d : D_W'(sha3_len(cmode));
    assign stream    = (st_q == StStream);
    assign xfer      = stream && dt_rdy;
    assign last      = (rem_q <= D_W'(OUT_W));
    assign take      = last ? rem_q : D_W'(OUT_W);
    assign rw        = IdxW'(rate_bits(mode_q) / OUT_W);

    squeeze_word_sel #(
        .OUT_W (OUT_W),
        .D_W   (D_W)
    ) u_word_sel (
        .state     (held_q),
        .idx       (idx_q),
        .remaining (rem_q),
        .last      (last),
        .word      (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= StIdle;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            StIdle:   if (start && start_ok) st_d = StWait;
            StWait:   if (state_vld) st_d = StStream;
            StStream: begin
                if (xfer) begin
                    if (last) begin
                        st_d = StIdle;
                    end else if (idx_q == rw - IdxW'(1)) begin
                        st_d = StReq;
                    end
                end
            end
            StReq:    st_d = StWait;
            default:  st_d = StIdle;
        endcase
    end

    always_comb begin
        dt_vld   = stream;
        dt_last  = stream && last;
        dt_o     = stream ? word : '0;
        perm_req = (st_q == StReq);
        busy     = (st_q != StIdle);
        err      = err_q;
    end

    always_comb begin
        mode_d = mode_q;
        rem_d  = rem_q;
        idx_d  = idx_q;
        held_d = held_q;
        err_d  = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (start && start_ok) begin
                    mode_d = cmode;
                    rem_d  = start_len;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            StWait: begin
                if (state_vld) begin
                    held_d = state_i;
                    idx_d  = '0;
                end
            end
            StStream: begin
                if (xfer) begin
                    rem_d = rem_q - take;
                    idx_d = idx_q + IdxW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
            rem_q  <= '0;
            idx_q  <= '0;
            held_q <= '0;
            err_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            rem_q  <= rem_d;
            idx_q  <= idx_d;
            held_q <= held_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_keccak_squeeze_out.sv
// Scoreboard bench for keccak_squeeze_out: expected beats are queued when a state
// block is driven and checked as the DUT hands them over.
module tb_keccak_squeeze_out;

    localparam int OUT_W = 32;
    localparam int D_W   = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       cmode = '0;
    logic [D_W-1:0]   d = '0;
    logic [1599:0]    state_i = '0;
    logic             state_vld = 1'b0;
    logic [OUT_W-1:0] dt_o;
    logic             dt_vld;
    logic             dt_rdy = 1'b1;
    logic             dt_last;
    logic             perm_req;
    logic             busy;
    logic             err;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;

    beat_t sb_q[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    beat_cnt = 0;
    int    perm_cnt = 0;
    bit    stall_en = 1'b0;
    int    rate_tab[6] = '{1152, 1088, 832, 576, 1344, 1088};
    int    len_tab[4] = '{224, 256, 384, 512};

    keccak_squeeze_out #(
        .OUT_W (OUT_W),
        .D_W   (D_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cmode     (cmode),
        .d         (d),
        .state_i   (state_i),
        .state_vld (state_vld),
        .dt_o      (dt_o),
        .dt_vld    (dt_vld),
        .dt_rdy    (dt_rdy),
        .dt_last   (dt_last),
        .perm_req  (perm_req),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ready pattern 1-0-0-1 when stalling is enabled.
    initial begin
        int cyc;
        logic [3:0] pat;
        cyc = 0;
        pat = 4'b1001;
        forever begin
            @(posedge clk);
            #1;
            dt_rdy = stall_en ? pat[cyc % 4] : 1'b1;
            cyc++;
        end
    end

    // Monitor: pops the scoreboard on each transfer and checks stall stability.
    initial begin
        logic             prev_hold;
        logic [OUT_W-1:0] prev_dt;
        logic             prev_last;
        beat_t            e;
        prev_hold = 1'b0;
        prev_dt   = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check_eq("hold_vld", 64'(dt_vld), 64'd1);
                    check_eq("hold_dt", 64'(dt_o), 64'(prev_dt));
                    check_eq("hold_last", 64'(dt_last), 64'(prev_last));
                end
                if (perm_req) perm_cnt++;
                if (dt_vld && dt_rdy) begin
                    beat_cnt++;
                    if (sb_q.size() == 0) begin
                        check_eq("extra_beat", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq($sformatf("beat%0d_data", beat_cnt), 64'(dt_o), 64'(e.data));
                        check_eq($sformatf("beat%0d_last", beat_cnt), 64'(dt_last), 64'(e.last));
                    end
                end
                prev_hold = dt_vld && !dt_rdy;
                prev_dt   = dt_o;
                prev_last = dt_last;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [1599:0] rand_state();
        logic [1599:0] s;
        for (int j = 0; j < 50; j++) s[j*32 +: 32] = $urandom;
        return s;
    endfunction

    task automatic push_block(input logic [1599:0] st, input int mode, inout int rem);
        int rw;
        rw = rate_tab[mode] / OUT_W;
        for (int i = 0; i < rw && rem > 0; i++) begin
            beat_t b;
            b.data = st[i*OUT_W +: OUT_W];
            b.last = (rem <= OUT_W);
            if (rem < OUT_W) begin
                for (int k = rem; k < OUT_W; k++) b.data[k] = 1'b0;
            end
            rem -= (rem < OUT_W) ? rem : OUT_W;
            sb_q.push_back(b);
        end
    endtask

    task automatic do_start(input logic [2:0] m, input logic [D_W-1:0] len);
        @(posedge clk);
        #1;
        start = 1'b1;
        cmode = m;
        d     = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_block(input logic [1599:0] st, input int mode, inout int rem);
        push_block(st, mode, rem);
        @(posedge clk);
        #1;
        check_eq("vld_before_state", 64'(dt_vld), 64'd0);
        state_i   = st;
        state_vld = 1'b1;
        @(posedge clk);
        #1;
        state_vld = 1'b0;
        check_eq("vld_latency", 64'(dt_vld), 64'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_eq("drain_in_time", 64'(sb_q.size() == 0), 64'd1);
    endtask

    task automatic run_fixed(input logic [2:0] m, input logic [1599:0] st, input int exp_beats,
                             input string tag);
        int rem;
        rem      = len_tab[m];
        beat_cnt = 0;
        perm_cnt = 0;
        do_start(m, '0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd1);
        send_block(st, int'(m), rem);
        wait_drain(400);
        @(posedge clk);
        #1;
        check_eq({tag, "_idle"}, 64'(busy), 64'd0);
        check_eq({tag, "_beats"}, 64'(beat_cnt), 64'(exp_beats));
        check_eq({tag, "_perm"}, 64'(perm_cnt), 64'd0);
    endtask

    task automatic err_start(input logic [2:0] m, input logic [D_W-1:0] len, input string tag);
        do_start(m, len);
        check_eq({tag, "_err"}, 64'(err), 64'd1);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_err_clr"}, 64'(err), 64'd0);
    endtask

    initial begin
        logic [1599:0] s;
        int            rem;
        int            n;

        #2;
        check_eq("rst_dt_o", 64'(dt_o), 64'd0);
        check_eq("rst_vld", 64'(dt_vld), 64'd0);
        check_eq("rst_last", 64'(dt_last), 64'd0);
        check_eq("rst_perm", 64'(perm_req), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // SHA3-256 with incrementing 64-bit lanes.
        for (int j = 0; j < 25; j++) s[j*64 +: 64] = 64'(j + 1);
        run_fixed(3'd1, s, 8, "sha256_inc");
        run_fixed(3'd0, rand_state(), 7, "sha224");
        run_fixed(3'd3, rand_state(), 16, "sha512");

        // SHAKE128, 1400 bits: one full rate block, a permutation request, then 2 beats.
        beat_cnt = 0;
        perm_cnt = 0;
        rem      = 1400;
        do_start(3'd4, 16'd1400);
        send_block(rand_state(), 4, rem);
        wait_drain(400);
        @(posedge clk);
        #1;
        check_eq("shake_beats_blk1", 64'(beat_cnt), 64'd42);
        check_eq("shake_perm_req", 64'(perm_req), 64'd1);
        check_eq("shake_busy_req", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        check_eq("shake_perm_pulse", 64'(perm_req), 64'd0);
        check_eq("shake_no_beat_wait", 64'(dt_vld), 64'd0);
        s = rand_state();
        s[63:56] = 8'hA5;
        send_block(s, 4, rem);
        wait_drain(400);
        @(posedge clk);
        #1;
        check_eq("shake_idle", 64'(busy), 64'd0);
        check_eq("shake_beats_total", 64'(beat_cnt), 64'd44);
        check_eq("shake_perm_cnt", 64'(perm_cnt), 64'd1);

        // Backpressure on SHA3-384.
        stall_en = 1'b1;
        run_fixed(3'd2, rand_state(), 12, "sha384_bp");
        stall_en = 1'b0;

        err_start(3'd6, 16'd100, "bad_cmode");
        err_start(3'd5, 16'd0, "shake_d0");

        // Start while busy must neither raise err nor alter the running digest.
        beat_cnt = 0;
        rem      = 256;
        do_start(3'd1, '0);
        do_start(3'd3, '0);
        check_eq("busy_start_err", 64'(err), 64'd0);
        check_eq("busy_start_busy", 64'(busy), 64'd1);
        send_block(rand_state(), 1, rem);
        wait_drain(400);
        @(posedge clk);
        #1;
        check_eq("busy_start_beats", 64'(beat_cnt), 64'd8);
        check_eq("busy_start_idle", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a SHA3-512 stream.
        beat_cnt = 0;
        rem      = 512;
        do_start(3'd3, '0);
        send_block(rand_state(), 3, rem);
        n = 0;
        while (beat_cnt < 3 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_eq("rst_mid_reached", 64'(beat_cnt >= 3), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_dt_o", 64'(dt_o), 64'd0);
        check_eq("rst_mid_vld", 64'(dt_vld), 64'd0);
        check_eq("rst_mid_last", 64'(dt_last), 64'd0);
        check_eq("rst_mid_perm", 64'(perm_req), 64'd0);
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_err", 64'(err), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_fixed(3'd1, rand_state(), 8, "post_rst_sha256");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
